sqrt_rom_reader: RTL and testbench

- Request-side controller for the 256-entry square-root ROM: accepts a wide unsigned operand, issues one ROM read, returns a fixed-point square root.
- ROM contract: entry a = floor(sqrt(a)*128), 11-bit data, 8-bit address, one-cycle registered read gated by enable.
- Operand is normalised by even right-shifts into the 8-bit address range; the ROM word is rescaled by half the shift.
- Sits between the variance accumulator and the classifier threshold scaler, with a valid/ready stream on both sides.

---
 rtl/sqrt_pkg.sv | 20 ++
 rtl/sqrt_denorm.sv | 42 ++++
 rtl/sqrt_rom_reader.sv | 151 +++++++++++++++
 tb/tb_sqrt_rom_reader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root ROM request controller.
// Optional rounding is enabled with the SQRT_ROUND_EN macro.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        READ  = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int ROM_FRAC  = 7;
    localparam int ROM_DEPTH = 256;

    function automatic int out_width(input int w_in, input int w_frac);
        return w_in / 2 + w_frac;
    endfunction

endpackage

// File: rtl/sqrt_denorm.sv
// Rescales a ROM word by the normalisation shift count into the output format.
// SQRT_ROUND_EN selects round-half-up instead of truncation.
module sqrt_denorm
    import sqrt_pkg::*;
#(
    parameter int W_IN       = 24,
    parameter int W_FRAC     = 0,
    parameter int W_ROM_DATA = 11,
    parameter int KW         = 5
) (
    input  logic [W_ROM_DATA-1:0]               rom_data,
    input  logic [KW-1:0]                       k,
    output logic [out_width(W_IN, W_FRAC)-1:0]  result
);

    localparam int OUT_W  = out_width(W_IN, W_FRAC);
    localparam int K_MAX  = (W_IN - 8) / 2;
    // One spare bit above the worst-case left shift absorbs the rounding carry.
    localparam int WI     = W_ROM_DATA + K_MAX + 1;
    localparam int SR     = ROM_FRAC - W_FRAC;
    localparam int RND_SH = (SR > 0) ? (SR - 1) : 0;
    localparam logic [WI-1:0] RND = (SR > 0) ? (WI'(1) << RND_SH) : WI'(0);

    logic [WI-1:0] shl_s;
    logic [WI-1:0] sum_s;

    // Left shift by half the normalisation, optional rounding, then drop surplus fraction bits.
    always_comb begin
        shl_s = WI'(rom_data) << k;
`ifdef SQRT_ROUND_EN
        if (SR > 0) begin
            sum_s = shl_s + RND;
        end else begin
            sum_s = shl_s;
        end
`else
        sum_s = shl_s;
`endif
        result = OUT_W'(sum_s >> SR);
    end

endmodule

// File: rtl/sqrt_rom_reader.sv
// Request-side controller for the 256-entry sqrt ROM: normalise, read, rescale.
// Build with SQRT_ROUND_EN defined for a rounded rather than truncated result.
module sqrt_rom_reader
    import sqrt_pkg::*;
#(
    parameter int W_IN       = 24,
    parameter int W_FRAC     = 0,
    parameter int W_ROM_ADDR = 8,
    parameter int W_ROM_DATA = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [W_IN-1:0]                     din,
    input  logic                                din_valid,
    output logic                                din_ready,
    output logic [out_width(W_IN, W_FRAC)-1:0]  dout,
    output logic                                dout_valid,
    input  logic                                dout_ready,
    output logic                                rom_ena,
    output logic [W_ROM_ADDR-1:0]               rom_addr,
    input  logic [W_ROM_DATA-1:0]               rom_data
);

    localparam int OUT_W = out_width(W_IN, W_FRAC);
    localparam int KW    = $clog2(W_IN / 2) + 1;

    state_t              state_r;
    state_t              state_s;
    logic [W_IN-1:0]     x_r;
    logic [KW-1:0]       k_r;
    logic [OUT_W-1:0]    dout_r;
    logic                dout_valid_r;
    logic                rom_ena_r;
    logic [W_ROM_ADDR-1:0] rom_addr_r;
    logic                high_s;
    logic [OUT_W-1:0]    denorm_s;

    // The operand is normalised while any bit above the ROM address range is set.
    generate
        if (W_IN > W_ROM_ADDR) begin : g_high
            assign high_s = |x_r[W_IN-1:W_ROM_ADDR];
        end else begin : g_no_high
            assign high_s = 1'b0;
        end
    endgenerate

    assign din_ready  = (state_r == IDLE);
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign rom_ena    = rom_ena_r;
    assign rom_addr   = rom_addr_r;

    sqrt_denorm #(
        .W_IN       (W_IN),
        .W_FRAC     (W_FRAC),
        .W_ROM_DATA (W_ROM_DATA),
        .KW         (KW)
    ) u_denorm (
        .rom_data (rom_data),
        .k        (k_r),
        .result   (denorm_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (din_valid) begin
                    state_s = NORM;
                end else begin
                    state_s = IDLE;
                end
            end
            NORM: begin
                if (high_s) begin
                    state_s = NORM;
                end else begin
                    state_s = READ;
                end
            end
            READ:  state_s = LATCH;
            LATCH: state_s = DONE;
            DONE: begin
                if (dout_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; the ROM strobe is set on entry to READ so it is high only there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r          <= '0;
            k_r          <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            rom_ena_r    <= 1'b0;
            rom_addr_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (din_valid) begin
                        x_r <= din;
                        k_r <= '0;
                    end
                end
                NORM: begin
                    if (high_s) begin
                        x_r <= x_r >> 2;
                        k_r <= k_r + KW'(1);
                    end else begin
                        rom_ena_r  <= 1'b1;
                        rom_addr_r <= x_r[W_ROM_ADDR-1:0];
                    end
                end
                READ: begin
                    rom_ena_r  <= 1'b0;
                    rom_addr_r <= '0;
                end
                LATCH: begin
                    dout_r       <= denorm_s;
                    dout_valid_r <= 1'b1;
                end
                DONE: begin
                    if (dout_ready) begin
                        dout_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rom_ena_r    <= 1'b0;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_rom_reader.sv
// Directed bench for sqrt_rom_reader with an ideal registered sqrt ROM model.
// Expectations for din=1000 follow SQRT_ROUND_EN when it is defined.
module tb_sqrt_rom_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        rom_ena;
    logic [7:0]  rom_addr;
    logic [10:0] rom_data = 11'd0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sqrt_rom_reader dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rom_ena    (rom_ena),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    // floor(sqrt(a) * 128) == integer sqrt of a * 16384
    function automatic logic [10:0] rom_val(input logic [7:0] a);
        int n;
        int r;
        n = int'(a) * 16384;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return 11'(r);
    endfunction

    always @(posedge clk) begin
        if (rom_ena) rom_data <= rom_val(rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [23:0] x, input int exp_addr, input int exp_k,
                          input int exp_dout, input string tag);
        int cyc;
        int ena_cnt;
        logic [7:0] addr_seen;
        addr_seen = 8'd0;
        din = x;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        cyc = 1;
        ena_cnt = 0;
        while (dout_valid !== 1'b1 && cyc < 200) begin
            if (rom_ena === 1'b1) begin
                ena_cnt++;
                addr_seen = rom_addr;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_valid"},   32'(dout_valid), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_k + 4));
        check({tag, "_rom_ena"}, 32'(ena_cnt), 32'd1);
        check({tag, "_addr"},    32'(addr_seen), 32'(exp_addr));
        check({tag, "_dout"},    32'(dout), 32'(exp_dout));
        check({tag, "_busy"},    32'(din_ready), 32'd0);
    endtask

    task automatic handshake(input int exp_dout, input string tag);
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(din_ready), 32'd1);
        check({tag, "_hs_keep"},  32'(dout), 32'(exp_dout));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        din = 24'd0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout",     32'(dout), 32'd0);
        check("rst_valid",    32'(dout_valid), 32'd0);
        check("rst_rom_ena",  32'(rom_ena), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_din_ready", 32'(din_ready), 32'd1);

        run_op(24'd16, 16, 0, 4, "d16");
        handshake(4, "d16");
        run_op(24'd256, 64, 1, 16, "d256");
        handshake(16, "d256");
        run_op(24'd65536, 64, 5, 256, "d65536");
        handshake(256, "d65536");
`ifdef SQRT_ROUND_EN
        run_op(24'd1000, 250, 1, 32, "d1000");
        check("d1000_rom_data", 32'(rom_data), 32'h7e7);
        handshake(32, "d1000");
`else
        run_op(24'd1000, 250, 1, 31, "d1000");
        check("d1000_rom_data", 32'(rom_data), 32'h7e7);
        handshake(31, "d1000");
`endif
        run_op(24'd0, 0, 0, 0, "d0");
        handshake(0, "d0");

        // Stall in DONE with noise on the input side.
        run_op(24'd16777215, 255, 8, 4086, "dmax");
        for (int i = 0; i < 10; i++) begin
            din = 24'h000100 + 24'(i);
            din_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            check("stall_dout",  32'(dout), 32'd4086);
            check("stall_valid", 32'(dout_valid), 32'd1);
            check("stall_ready", 32'(din_ready), 32'd0);
        end
        din_valid = 1'b0;
        handshake(4086, "dmax");
        @(posedge clk); #1;
        check("post_stall_idle", 32'(rom_ena), 32'd0);

        // Reset while normalising.
        din = 24'd16777215;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("mid_rst_valid",   32'(dout_valid), 32'd0);
        check("mid_rst_rom_ena", 32'(rom_ena), 32'd0);
        check("mid_rst_dout",    32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready",  32'(din_ready), 32'd1);
        check("post_rst_valid",  32'(dout_valid), 32'd0);
        run_op(24'd9, 9, 0, 3, "d9");
        handshake(3, "d9");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
